// File: rtl/dbuf2ddr_if.sv
// dbuf2ddr_if: configuration, buffer-read and DDR-stream signals of the dbuf2ddr write-back block
interface dbuf2ddr_if #(parameter int ADDR_W = 8, PE_W = 5, PE_NUM = 32, DDR_W = 64);
  logic                    conf_valid;
  logic                    conf_ready;
  logic [ADDR_W-1:0]       conf_start_addr;
  logic [ADDR_W-1:0]       conf_word_num;
  logic [PE_W-1:0]         conf_pe_num;
  logic                    dbuf_rd_en;
  logic [ADDR_W-1:0]       dbuf_rd_addr;
  logic [PE_W-1:0]         dbuf_rd_sel;
  logic [PE_NUM*DDR_W-1:0] dbuf_rd_data;
  logic [DDR_W-1:0]        ddr_data;
  logic                    ddr_valid;
  logic                    ddr_last;
  logic                    ddr_ready;
  modport master (
    input  conf_valid, conf_start_addr, conf_word_num, conf_pe_num, dbuf_rd_data, ddr_ready,
    output conf_ready, dbuf_rd_en, dbuf_rd_addr, dbuf_rd_sel, ddr_data, ddr_valid, ddr_last
  );
  modport slave (
    output conf_valid, conf_start_addr, conf_word_num, conf_pe_num, dbuf_rd_data, ddr_ready,
    input  conf_ready, dbuf_rd_en, dbuf_rd_addr, dbuf_rd_sel, ddr_data, ddr_valid, ddr_last
  );
endinterface

// File: rtl/dbuf2ddr.sv
// dbuf2ddr: streams a rectangular region of the PE buffers to DDR, word-major; DBUF2DDR_RELU_EN clamps negative lanes to 0
module dbuf2ddr #(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(BUF_DEPTH),
  parameter int PE_NUM     = 32,
  parameter int PE_W       = $clog2(PE_NUM),
  parameter int DATA_W     = 16,
  parameter int BATCH      = 4,
  parameter int DDR_W      = DATA_W*BATCH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  dbuf2ddr_if.master bus
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] start_addr, word_num, word_cnt, c_start, c_wn, c_wc;
  logic [PE_W-1:0] pe_num, pe_cnt, c_pn, c_pc;
  logic rd_last, idle, issue, fin, drained, push, pop;
  logic [RD_LAT-1:0] v_pipe, l_pipe;
  logic [RD_LAT-1:0][PE_W-1:0] s_pipe;
  logic [DDR_W:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DDR_W-1:0] ret;
  int total;
  assign push = v_pipe[RD_LAT-1];
  assign pop = bus.ddr_valid && bus.ddr_ready;
  assign bus.conf_ready = state == IDLE;
  assign bus.ddr_valid = count != '0;
  assign bus.ddr_data = mem[rd_ptr][DDR_W-1:0];
  assign bus.ddr_last = bus.ddr_valid && mem[rd_ptr][DDR_W];
  // The accepting IDLE cycle issues the first read straight from the config inputs.
  always_comb begin
    idle = state == IDLE;
    c_start = idle ? bus.conf_start_addr : start_addr;
    c_wn = idle ? bus.conf_word_num : word_num;
    c_pn = idle ? bus.conf_pe_num : pe_num;
    c_wc = idle ? '0 : word_cnt;
    c_pc = idle ? '0 : pe_cnt;
    total = int'(count) + int'(bus.dbuf_rd_en) - int'(pop);
    for (int i = 0; i < RD_LAT; i++) total += int'(v_pipe[i]);
    issue = idle ? bus.conf_valid : (state == READ && total < FIFO_DEPTH);
    fin = issue && c_wc == c_wn && c_pc == c_pn;
    drained = !bus.dbuf_rd_en && v_pipe == '0 && (count == '0 || (count == CW'(1) && pop));
    state_nx = idle ? (issue ? (fin ? DRAIN : READ) : IDLE)
             : state == READ ? (fin ? DRAIN : READ)
             : (drained ? IDLE : DRAIN);
  end
  always_comb begin
    ret = bus.dbuf_rd_data[s_pipe[RD_LAT-1]*DDR_W +: DDR_W];
`ifdef DBUF2DDR_RELU_EN
    for (int i = 0; i < BATCH; i++) if (ret[i*DATA_W+DATA_W-1]) ret[i*DATA_W +: DATA_W] = '0;
`else
`endif
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr <= '0;
      word_num <= '0;
      pe_num <= '0;
      word_cnt <= '0;
      pe_cnt <= '0;
      bus.dbuf_rd_en <= 1'b0;
      bus.dbuf_rd_addr <= '0;
      bus.dbuf_rd_sel <= '0;
      rd_last <= 1'b0;
      v_pipe <= '0;
      l_pipe <= '0;
      s_pipe <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (idle && bus.conf_valid) begin
        start_addr <= bus.conf_start_addr;
        word_num <= bus.conf_word_num;
        pe_num <= bus.conf_pe_num;
      end
      bus.dbuf_rd_en <= issue;
      if (issue) begin
        bus.dbuf_rd_addr <= c_start + c_wc;
        bus.dbuf_rd_sel <= c_pc;
        rd_last <= fin;
        pe_cnt <= c_pc == c_pn ? '0 : c_pc + 1'b1;
        word_cnt <= c_wc + ADDR_W'(c_pc == c_pn);
      end
      v_pipe[0] <= bus.dbuf_rd_en;
      l_pipe[0] <= rd_last;
      s_pipe[0] <= bus.dbuf_rd_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
      end
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH-1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {l_pipe[RD_LAT-1], ret};
endmodule

// File: tb/tb_dbuf2ddr.sv
// tb_dbuf2ddr: directed vectors with a behavioural buffer model and beat/address scoreboard
module tb_dbuf2ddr;
  localparam int AW = 8, PW = 5, PN = 32, DW = 64;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dbuf2ddr_if #(.ADDR_W(AW), .PE_W(PW), .PE_NUM(PN), .DDR_W(DW)) bus();
  dbuf2ddr dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  bit ovr = 1'b0, bp = 1'b0, stalled = 1'b0;
  logic [AW-1:0] a_d1, a_d2;
  logic [64:0] held;
  logic [64:0] got[$], exp_q[$];
  logic [AW-1:0] got_addr[$], exp_addr[$];
  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask
  function automatic logic [63:0] pat(input int p, input int a);
    return {16'(p), 16'(a), 16'(p) ^ 16'h0F0F, 16'(a) ^ 16'h0F0F};
  endfunction
  function automatic logic [63:0] raw(input int p, input int a, input bit o);
    return (o && p == 0 && a == 0) ? 64'hFFFD_0007_8000_0001 : pat(p, a);
  endfunction
  function automatic logic [63:0] expw(input int p, input int a);
`ifdef DBUF2DDR_RELU_EN
    return (ovr && p == 0 && a == 0) ? 64'h0000_0007_0000_0001 : pat(p, a);
`else
    return (ovr && p == 0 && a == 0) ? 64'hFFFD_0007_8000_0001 : pat(p, a);
`endif
  endfunction
  always @(posedge clk) begin
    a_d1 <= bus.dbuf_rd_addr;
    a_d2 <= a_d1;
  end
  always_comb for (int p = 0; p < PN; p++) bus.dbuf_rd_data[p*DW +: DW] = raw(p, int'(a_d2), ovr);
  initial forever begin
    @(negedge clk);
    if (!rst && bus.dbuf_rd_en) got_addr.push_back(bus.dbuf_rd_addr);
    if (!rst && stalled && bus.ddr_valid) check("hold", {bus.ddr_last, bus.ddr_data}, held);
    stalled = !rst && bus.ddr_valid && !bus.ddr_ready;
    held = {bus.ddr_last, bus.ddr_data};
    if (!rst && bus.ddr_valid && bus.ddr_ready) got.push_back({bus.ddr_last, bus.ddr_data});
  end
  initial forever begin
    @(posedge clk);
    #1 bus.ddr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic conf(input int sa, input int wn, input int pn);
    bus.conf_start_addr = AW'(sa);
    bus.conf_word_num = AW'(wn);
    bus.conf_pe_num = PW'(pn);
    bus.conf_valid = 1'b1;
    @(posedge clk);
    #1 bus.conf_valid = 1'b0;
  endtask
  task automatic run(input int sa, input int wn, input int pn, input bit busy, input bit timing);
    int n, cyc;
    n = (wn + 1) * (pn + 1);
    exp_q.delete(); exp_addr.delete(); got.delete(); got_addr.delete();
    for (int w = 0; w <= wn; w++)
      for (int p = 0; p <= pn; p++) begin
        exp_q.push_back({1'(w == wn && p == pn), expw(p, (sa + w) % 256)});
        exp_addr.push_back(AW'((sa + w) % 256));
      end
    conf(sa, wn, pn);
    check("conf_ready_drop", bus.conf_ready, 0);
    cyc = 1;
    if (timing) begin
      while (!bus.ddr_valid && cyc < 50) begin
        @(posedge clk);
        #1 cyc++;
      end
      check("first_valid_latency", cyc, 4);
    end
    if (busy) begin
      bus.conf_start_addr = 8'd99;
      bus.conf_word_num = 8'd0;
      bus.conf_pe_num = 5'd7;
      bus.conf_valid = 1'b1;
      check("busy_ready_before", bus.conf_ready, 0);
      @(posedge clk);
      #1 bus.conf_valid = 1'b0;
      check("busy_ready_after", bus.conf_ready, 0);
    end
    cyc = 0;
    while (got.size() < n && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("beat_count", got.size(), n);
    check("ready_after_last", bus.conf_ready, 1);
    for (int i = 0; i < n && i < got.size(); i++) check($sformatf("beat%0d", i), got[i], exp_q[i]);
    check("addr_count", got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) check($sformatf("addr%0d", i), got_addr[i], exp_addr[i]);
  endtask
  initial begin
    int cyc;
    bus.conf_valid = 1'b0;
    bus.conf_start_addr = '0;
    bus.conf_word_num = '0;
    bus.conf_pe_num = '0;
    bus.ddr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_conf_ready", bus.conf_ready, 1);
    check("rst_ddr_valid", bus.ddr_valid, 0);
    check("rst_ddr_last", bus.ddr_last, 0);
    check("rst_rd_en", bus.dbuf_rd_en, 0);
    check("rst_rd_addr", bus.dbuf_rd_addr, 0);
    check("rst_rd_sel", bus.dbuf_rd_sel, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(0, 1, 1, 1'b0, 1'b1);
    run(254, 3, 0, 1'b0, 1'b0);
    bp = 1'b1;
    run(5, 7, 3, 1'b0, 1'b0);
    bp = 1'b0;
    @(posedge clk);
    #1;
    run(40, 3, 1, 1'b1, 1'b0);
    got.delete();
    conf(10, 3, 3);
    cyc = 0;
    while (got.size() < 5 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("pre_reset_beats", got.size() >= 5, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_ddr_valid", bus.ddr_valid, 0);
    check("mid_rst_rd_en", bus.dbuf_rd_en, 0);
    check("mid_rst_conf_ready", bus.conf_ready, 1);
    repeat (5) @(posedge clk);
    #1 check("no_stale_valid", bus.ddr_valid, 0);
    run(20, 3, 3, 1'b0, 1'b0);
    ovr = 1'b1;
    run(0, 0, 0, 1'b0, 1'b0);
    ovr = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbuf2ddr.md
Name: dbuf2ddr

Overview:
- Write-back counterpart of the DDR-to-dbuf loader: reads result words out of the per-PE buffers and streams them to DDR as single-beat valid/ready transfers.
- One configuration covers a rectangular region: words start_addr..start_addr+word_num of PEs 0..pe_num.
- Output order is word-major: for each buffer address, PE 0 through pe_num.
- An internal credit-controlled FIFO absorbs DDR backpressure, so buffer reads are never lost.

Parameters:
- BUF_DEPTH, 256, words per PE buffer.
- ADDR_W, bw(BUF_DEPTH), buffer address width.
- PE_NUM, 32, number of PE buffers.
- PE_W, bw(PE_NUM), PE select width.
- DATA_W, 16, sample width (signed two's complement).
- BATCH, 4, samples per buffer word.
- DDR_W, DATA_W*BATCH, DDR beat width; one buffer word per beat.
- RD_LAT, 2, fixed buffer read latency in cycles (1..3).
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- conf_valid  in  1  configuration request
- conf_ready  out  1  block idle, accepts configuration
- conf_start_addr  in  ADDR_W  first buffer address
- conf_word_num  in  ADDR_W  words per PE minus 1
- conf_pe_num  in  PE_W  last PE index (PEs 0..conf_pe_num)
- dbuf_rd_en  out  1  buffer read strobe
- dbuf_rd_addr  out  ADDR_W  buffer read address
- dbuf_rd_sel  out  PE_W  PE being read
- dbuf_rd_data  in  PE_NUM*DDR_W  all PE read ports, PE p at [p*DDR_W +: DDR_W], valid RD_LAT cycles after dbuf_rd_en
- ddr_data  out  DDR_W  output beat
- ddr_valid  out  1  beat valid
- ddr_last  out  1  final beat of the configuration
- ddr_ready  in  1  DDR sink accepts beat

Behaviour:
- Reset values: conf_ready=1, ddr_valid=0, ddr_last=0, dbuf_rd_en=0, dbuf_rd_addr=0, dbuf_rd_sel=0. FIFO is emptied, the in-flight pipeline is cleared and state goes to IDLE.
- Reset mid-operation aborts all work immediately; no partial beats appear after reset.
- States:
  - IDLE: conf_ready=1. conf_valid&&conf_ready latches start_addr/word_num/pe_num, clears word_cnt and pe_cnt, goes to READ. conf_ready drops the next cycle.
  - READ: issue a read (dbuf_rd_en=1, registered outputs) in any cycle where (FIFO occupancy + reads in flight + 1) <= FIFO_DEPTH.
    - dbuf_rd_addr = (start_addr + word_cnt) mod BUF_DEPTH; the address wraps past BUF_DEPTH-1 to 0.
    - dbuf_rd_sel = pe_cnt.
    - pe_cnt advances each issue. At conf_pe_num it resets to 0 and word_cnt increments.
    - Issuing the read with word_cnt==word_num and pe_cnt==pe_num moves the FSM to DRAIN.
  - DRAIN: no reads. Once in-flight==0, FIFO empty and the last beat has been accepted, go to IDLE; conf_ready=1 the following cycle.
- conf_valid outside IDLE is ignored; parameters are held for the whole transfer.
- Read return path:
  - An RD_LAT-deep shift register carries valid, sel and a last flag alongside each read.
  - On return, the selected DDR_W slice of dbuf_rd_data is muxed and pushed into the FIFO with its last flag.
- Output:
  - ddr_valid = FIFO not empty; ddr_data/ddr_last come from the FIFO head. Pop on ddr_valid&&ddr_ready.
  - ddr_data and ddr_last are held stable while ddr_valid=1 and ddr_ready=0.
- Latency: config accepted at cycle T → first dbuf_rd_en at T+1 → data at T+1+RD_LAT → ddr_valid at T+2+RD_LAT.
- Throughput: 1 beat/cycle sustained while ddr_ready=1.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged. The credit rule guarantees no push into a truly full FIFO.
- Total beats = (word_num+1)*(pe_num+1). ddr_last is asserted on exactly one beat, the final one.

Optional Feature:
- Macro DBUF2DDR_RELU_EN.
- Defined: each DATA_W lane of the returned word is clamped to 0 if its sign bit is 1, applied before the FIFO push. Adds no latency.
- Undefined: data passes through unmodified.

Test Plan:
- Basic: start_addr=0, word_num=1, pe_num=1, ddr_ready=1, PE p word a = {p,a} pattern.
  - Expect 4 beats in order (a0,p0),(a0,p1),(a1,p0),(a1,p1).
  - First ddr_valid at T+4 (RD_LAT=2); ddr_last only on the 4th beat; conf_ready=1 one cycle after the last pop.
- Wrap: start_addr=254, word_num=3, pe_num=0.
  - Expect dbuf_rd_addr sequence 254,255,0,1 and 4 beats.
- Backpressure: word_num=7, pe_num=3, ddr_ready toggling 1-0-0-1 randomly.
  - Expect all 32 beats, in order, none lost or duplicated.
  - FIFO occupancy never exceeds 4; data held stable while stalled.
- Busy config: pulse conf_valid mid-transfer with different parameters.
  - Expect it ignored: beat count and addresses unchanged, conf_ready stays 0.
- Reset mid-stream: assert rst after 5 of 16 beats.
  - Next cycle expect ddr_valid=0, dbuf_rd_en=0, conf_ready=1.
  - A new config then produces its full beat count with no stale data.
- RELU (macro defined): PE0 word0 lanes = {-3, 7, 0x8000, 1}.
  - Expect beat lanes {0, 7, 0, 1}.
  - With the macro undefined, expect the raw values.
